// File: rtl/bcd_multiword_add_ctrl.sv
// Multi-word packed-BCD adder sequencer.
// Adds two WORDS x 4-digit BCD operands one 16-bit chunk per cycle (LS chunk
// first) through a single shared 4-digit BCD adder, chaining the carry between
// chunks. Operands are digit-checked before the add starts; start/busy/done
// handshake towards the host.

// Combinational 4-digit packed-BCD adder with ripple carry between digits.
module bcd_adder_4digits (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    // One decimal digit: returns {carry, digit}; adding 6 skips the six
    // unused nibble codes so the low nibble wraps to the correct digit.
    function automatic logic [4:0] bcd_digit_add(input logic [3:0] x,
                                                 input logic [3:0] y,
                                                 input logic       c);
        logic [4:0] s;
        s = {1'b0, x} + {1'b0, y} + {4'b0000, c};
        if (s > 5'd9) begin
            s = s + 5'd6;
        end else begin
            s = s;
        end
        return s;
    endfunction

    // Ripple the decimal carry from digit 0 to digit 3.
    always_comb begin
        logic       c;
        logic [4:0] d;
        c   = cin;
        sum = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            d              = bcd_digit_add(a[4*i +: 4], b[4*i +: 4], c);
            sum[4*i +: 4]  = d[3:0];
            c              = d[4];
        end
        cout = c;
    end

endmodule

module bcd_multiword_add_ctrl #(
    parameter int WORDS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [16*WORDS-1:0] a,
    input  logic [16*WORDS-1:0] b,
    input  logic                cin,
    output logic                busy,
    output logic                done,
    output logic [16*WORDS-1:0] sum,
    output logic                cout,
    output logic                err
);

    localparam int W  = 16 * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   sum_q, sum_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           carry_q, carry_d;
    logic           cout_q, cout_d;
    logic           err_q, err_d;

    logic           bad_digit_s;
    logic           last_chunk_s;
    logic [15:0]    chunk_a_s;
    logic [15:0]    chunk_b_s;
    logic [15:0]    add_sum_s;
    logic           add_cout_s;

    // True when any nibble of the operand is not a decimal digit (> 9).
    function automatic logic has_bad_digit(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < 4 * WORDS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end else begin
                bad = bad;
            end
        end
        return bad;
    endfunction

    // Operands are checked as presented at the accepting edge, which are
    // exactly the values being latched, so a bad digit can skip RUN entirely.
    assign bad_digit_s  = has_bad_digit(a) | has_bad_digit(b);
    assign last_chunk_s = (idx_q == LAST_IDX);

    // Select the current chunk of each latched operand for the shared adder.
    always_comb begin
        chunk_a_s = 16'h0000;
        chunk_b_s = 16'h0000;
        for (int i = 0; i < WORDS; i++) begin
            if (idx_q == i[IW-1:0]) begin
                chunk_a_s = a_q[16*i +: 16];
                chunk_b_s = b_q[16*i +: 16];
            end else begin
                chunk_a_s = chunk_a_s;
                chunk_b_s = chunk_b_s;
            end
        end
    end

    bcd_adder_4digits u_adder (
        .a    (chunk_a_s),
        .b    (chunk_b_s),
        .cin  (carry_q),
        .sum  (add_sum_s),
        .cout (add_cout_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: invalid operands go straight to DONE with err set.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = bad_digit_s ? ST_DONE : ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_chunk_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: latch on accept, write one chunk per RUN cycle;
    // the adder result is only ever captured while in RUN.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d    = a;
                    b_d    = b;
                    sum_d  = '0;
                    cout_d = 1'b0;
                    idx_d  = '0;
                    if (bad_digit_s) begin
                        err_d   = 1'b1;
                        carry_d = 1'b0;
                    end else begin
                        err_d   = 1'b0;
                        carry_d = cin;
                    end
                end else begin
                    a_d = a_q;
                    b_d = b_q;
                end
            end
            ST_RUN: begin
                for (int i = 0; i < WORDS; i++) begin
                    if (idx_q == i[IW-1:0]) begin
                        sum_d[16*i +: 16] = add_sum_s;
                    end else begin
                        sum_d[16*i +: 16] = sum_q[16*i +: 16];
                    end
                end
                carry_d = add_cout_s;
                idx_d   = idx_q + IW'(1);
                if (last_chunk_s) begin
                    cout_d = add_cout_s;
                end else begin
                    cout_d = cout_q;
                end
            end
            ST_DONE: begin
                idx_d = '0;
            end
            default: begin
                idx_d = '0;
            end
        endcase
    end

    // Datapath registers; reset also clears the visible results.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
        end
    end

    // Handshake outputs decode straight from the state flops.
    assign busy = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign err  = err_q;

endmodule

// File: tb/tb_bcd_multiword_add_ctrl.sv
// Directed self-checking bench for bcd_multiword_add_ctrl with WORDS=4.
module tb_bcd_multiword_add_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [63:0] sum;
    logic        cout;
    logic        err;

    int n_cmp;
    int n_mis;

    bcd_multiword_add_ctrl #(.WORDS(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one start pulse; lat = edges after the accepting edge until done
    // is seen, bcnt = sampled cycles with busy high from the accept onwards.
    task automatic run_op(input logic [63:0] ta, input logic [63:0] tb_v, input logic tc,
                          output int lat, output int bcnt);
        @(negedge clk);
        a = ta; b = tb_v; cin = tc; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat  = 0;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (busy) bcnt++;
        end
        if (lat >= 20) chk("done_timeout", 64'(lat), 64'd0);
    endtask

    // Confirm done was a single-cycle pulse and the block returned to idle.
    task automatic chk_idle_after(input string tag);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_done_drop"}, {63'd0, done}, 64'd0);
        chk({tag, "_busy_drop"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        int lat, bcnt, cnt, dcnt;
        n_cmp = 0; n_mis = 0;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_sum",  sum, 64'd0);
        chk("rst_cout", {63'd0, cout}, 64'd0);
        chk("rst_err",  {63'd0, err}, 64'd0);
        rst = 1'b0;

        // 1: basic add, latency and busy length.
        run_op(64'h0000_0000_0000_1234, 64'h0000_0000_0000_5678, 1'b0, lat, bcnt);
        chk("s1_sum",  sum, 64'h0000_0000_0000_6912);
        chk("s1_cout", {63'd0, cout}, 64'd0);
        chk("s1_err",  {63'd0, err}, 64'd0);
        chk("s1_lat",  64'(lat), 64'd4);
        chk("s1_busy", 64'(bcnt), 64'd5);
        chk_idle_after("s1");
        chk("s1_hold", sum, 64'h0000_0000_0000_6912);

        // 2: carry across a chunk boundary.
        run_op(64'h0000_0000_0000_9999, 64'h0000_0000_0000_0001, 1'b0, lat, bcnt);
        chk("s2_sum",  sum, 64'h0000_0000_0001_0000);
        chk("s2_cout", {63'd0, cout}, 64'd0);

        // 3: full-width carry chain and wrap-around.
        run_op(64'h9999_9999_9999_9999, 64'h9999_9999_9999_9999, 1'b1, lat, bcnt);
        chk("s3a_sum",  sum, 64'h9999_9999_9999_9999);
        chk("s3a_cout", {63'd0, cout}, 64'd1);
        run_op(64'h9999_9999_9999_9999, 64'h0000_0000_0000_0000, 1'b1, lat, bcnt);
        chk("s3b_sum",  sum, 64'h0000_0000_0000_0000);
        chk("s3b_cout", {63'd0, cout}, 64'd1);

        // Put a non-zero result in place so the error path must clear it.
        run_op(64'h0000_0000_0000_1234, 64'h0000_0000_0000_5678, 1'b1, lat, bcnt);
        chk("pre4_sum", sum, 64'h0000_0000_0000_6913);

        // 4: invalid digit in a.
        run_op(64'h0000_0000_0000_00A0, 64'h0000_0000_0000_0000, 1'b0, lat, bcnt);
        chk("s4_err",  {63'd0, err}, 64'd1);
        chk("s4_sum",  sum, 64'd0);
        chk("s4_cout", {63'd0, cout}, 64'd0);
        chk("s4_lat",  64'(lat), 64'd0);
        chk_idle_after("s4");
        chk("s4_hold", sum, 64'd0);
        // Invalid digit in b, then a valid add must clear err.
        run_op(64'h0000_0000_0000_0001, 64'h0F00_0000_0000_0000, 1'b0, lat, bcnt);
        chk("s4b_err", {63'd0, err}, 64'd1);
        run_op(64'h0000_0000_0000_0005, 64'h0000_0000_0000_0005, 1'b0, lat, bcnt);
        chk("s4c_err", {63'd0, err}, 64'd0);
        chk("s4c_sum", sum, 64'h0000_0000_0000_0010);

        // 5a: start and operand changes during RUN are ignored.
        @(negedge clk);
        a = 64'h0000_0000_0000_1234; b = 64'h0000_0000_0000_5678; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b1; a = 64'h1111_1111_1111_1111; b = 64'h1111_1111_1111_1111; cin = 1'b1;
        cnt = 0;
        while (!done && cnt < 20) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
        end
        start = 1'b0;
        chk("s5a_lat",  64'(cnt), 64'd3);
        chk("s5a_sum",  sum, 64'h0000_0000_0000_6912);
        chk("s5a_cout", {63'd0, cout}, 64'd0);
        chk_idle_after("s5a");

        // 5b: start held high gives back-to-back operations 6 cycles apart.
        @(negedge clk);
        a = 64'h0000_0000_0000_1234; b = 64'h0000_0000_0000_5678; cin = 1'b0; start = 1'b1;
        cnt = 0;
        while (!done && cnt < 20) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
        end
        chk("s5b_first", 64'(cnt), 64'd5);
        cnt = 0;
        do begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
        end while (!done && cnt < 20);
        start = 1'b0;
        chk("s5b_gap", 64'(cnt), 64'd6);
        chk("s5b_sum", sum, 64'h0000_0000_0000_6912);
        chk_idle_after("s5b");

        // 6: reset after two chunks aborts without a done pulse.
        @(negedge clk);
        a = 64'h9999_9999_9999_9999; b = 64'h9999_9999_9999_9999; cin = 1'b1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("s6_partial", sum, 64'h0000_0000_9999_9999);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("s6_busy", {63'd0, busy}, 64'd0);
        chk("s6_sum",  sum, 64'd0);
        chk("s6_cout", {63'd0, cout}, 64'd0);
        chk("s6_done", {63'd0, done}, 64'd0);
        rst = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("s6_no_done", 64'(dcnt), 64'd0);
        run_op(64'h0000_0000_0000_9999, 64'h0000_0000_0000_0001, 1'b0, lat, bcnt);
        chk("s6_s2_sum",  sum, 64'h0000_0000_0001_0000);
        chk("s6_s2_cout", {63'd0, cout}, 64'd0);
        chk("s6_s2_lat",  64'(lat), 64'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
